key_count_disp: RTL and testbench
=================================

// Module: key_count_disp
// PURPOSE
//  Parametrised key-press counter with multiplexed 7-segment scan output.
//  - Counts debounced key events on N_CH channels as multi-digit BCD, up or down.
//  - Maps each channel onto CNT_DIGITS display digits.
//  - Time-multiplexes all N_DIGITS digits onto one seg/sel pair for the shift-register display driver.
//  - Sits between the per-key debounce filters and the display driver.
// PARAMETERS
//  N_CH        4      number of key channels (1..8)
//  CNT_DIGITS  1      BCD digits per channel counter (1..3)
//  N_DIGITS    6      display digits; N_CH*CNT_DIGITS <= N_DIGITS, else elaboration $error
//  SCAN_DIV    65536  clk cycles per digit dwell (>=2); prescaler width $clog2(SCAN_DIV)
// PORTS
//  clk    in   1           system clock, all logic on posedge
//  rst    in   1           asynchronous, active-high reset
//  key_n  in   N_CH        debounced keys, active-low (0 = pressed)
//  up_dn  in   1           1 = count up, 0 = count down; sampled per event
//  clr    in   1           synchronous clear of all counters
//  seg    out  8           segments {a,b,c,d,e,f,g,dp}, active-low (0 = lit)
//  sel    out  N_DIGITS    one-hot digit select; sel[0] = rightmost digit
//  ovf    out  N_CH        1-cycle pulse when a channel counter wraps
// BEHAVIOUR
//  Reset values: seg=8'hFF, sel=1, ovf=0, all counters 0, prescaler 0, key_q=all-1.
//  Event detect:
//   - key_q registers key_n.
//   - Event on channel i when key_n[i]==0 && key_q[i]==1.
//   - A held key counts once; a new event needs a release first.
//  Counter update: registered at the edge that samples the event; visible 1 cycle later.
//   - Up: BCD increment with carry. All-9s -> all-0s, ovf[i]=1 for that cycle.
//   - Down: BCD decrement with borrow. All-0s -> all-9s, ovf[i]=1.
//   - Digits never hold A-F.
//   - Channels are independent; simultaneous events all apply in the same cycle.
//  clr:
//   - Has priority over same-cycle events: counters -> 0, ovf -> 0.
//   - Does not affect the scan; key_q still updates.
//  Digit map:
//   - Display digit d shows digit (d % CNT_DIGITS) of channel (d / CNT_DIGITS).
//   - d >= N_CH*CNT_DIGITS shows 8'hFF (blank). No leading-zero suppression.
//  Decode (a..g,dp):
//   0=03  1=9F  2=25  3=0D  4=99  5=49  6=41  7=1F  8=01  9=09
//  Scan:
//   - Prescaler runs 0..SCAN_DIV-1 and wraps.
//   - On the edge where prescaler==SCAN_DIV-1, sel rotates left one-hot (bit N_DIGITS-1 -> bit 0).
//   - On that same edge seg loads the decoded digit for the NEW sel value.
//   - seg is stable for the whole dwell; count changes show at the digit's next visit.
//  Reset mid-operation: all state returns to reset values immediately (async); no event is lost or replayed after release.
// CONFIGURATION
//  KEY_DISP_DP_EN defined:
//   - last_ch register (valid flag + index) loads on every event; lowest index wins on simultaneous events.
//   - dp (seg[0]) is driven 0 on digit 0 of channel last_ch, only while valid.
//   - valid resets to 0 and is cleared by clr.
//  KEY_DISP_DP_EN undefined: no last_ch register; seg[0] always 1.
// TESTING  (N_CH=4, CNT_DIGITS=1, N_DIGITS=6, SCAN_DIV=4 unless noted)
//  1. rst=1 -> seg=FF, sel=000001, ovf=0; release, 4 clks -> sel=000010, seg=03.
//  2. 3 falling edges on key_n[0], up_dn=1 -> while sel=000001, seg=0D; ovf stays 0.
//  3. 10 events on ch2 -> count 0, ovf[2] high exactly 1 cycle on the 10th; sel=000100 shows 03.
//  4. up_dn=0, 1 event on ch1 from 0 -> digit1 seg=09, ovf[1] 1-cycle pulse; sel=010000 and 100000 show FF.
//  5. key_n[3] held low 20 clks -> count 1 only; clr with a same-cycle key_n[0] edge -> all counts 0, ovf=0.
//  6. N_CH=3, CNT_DIGITS=2, KEY_DISP_DP_EN: 15 events ch0 -> d1=9F, d0=49 with dp lit (48);
//     85 more -> 00, ovf[0] pulse.

Source files
------------

// File: rtl/key_count_disp_if.sv
// Key/display bundle between the host side and key_count_disp.
// Master drives keys and controls; slave returns scan and overflow.
interface key_count_disp_if #(
    parameter int N_CH     = 4,
    parameter int N_DIGITS = 6
);
    logic [N_CH-1:0]     key_n;
    logic                up_dn;
    logic                clr;
    logic [7:0]          seg;
    logic [N_DIGITS-1:0] sel;
    logic [N_CH-1:0]     ovf;

    modport master (
        output key_n, up_dn, clr,
        input  seg, sel, ovf
    );

    modport slave (
        input  key_n, up_dn, clr,
        output seg, sel, ovf
    );
endinterface

// File: rtl/key_count_disp.sv
// Multi-channel BCD key-press counter with multiplexed 7-segment scan.
// Optional KEY_DISP_DP_EN lights the dp of the most recently pressed channel.
module key_count_disp #(
    parameter int N_CH       = 4,
    parameter int CNT_DIGITS = 1,
    parameter int N_DIGITS   = 6,
    parameter int SCAN_DIV   = 65536
) (
    input logic              clk,
    input logic              rst,
    key_count_disp_if.slave  bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int NU = N_CH * CNT_DIGITS;

    if (NU > N_DIGITS) begin : g_cfg_err
        $error("key_count_disp: N_CH*CNT_DIGITS exceeds N_DIGITS");
    end

    typedef logic [CNT_DIGITS-1:0][3:0] bcd_t;

    logic [N_CH-1:0]                  key_q;
    logic [N_CH-1:0]                  ev;
    bcd_t [N_CH-1:0]                  cnt;
    bcd_t [N_CH-1:0]                  nxt;
    logic [N_CH-1:0]                  wrap;
    logic [N_CH-1:0]                  ovf_q;
    logic [PW-1:0]                    pre;
    logic [IW-1:0]                    dig;
    logic [IW-1:0]                    nxt_idx;
    logic [N_DIGITS-1:0]              sel_q;
    logic [7:0]                       seg_q;
    logic [7:0]                       seg_nxt;
    logic                             dp_lit;

    // Returns {wrap, value}; a carry/borrow out of the top digit is a wrap.
    function automatic logic [4*CNT_DIGITS:0] bcd_step(input bcd_t v,
                                                       input logic up);
        bcd_t r;
        logic c;
        r = v;
        c = 1'b1;
        for (int k = 0; k < CNT_DIGITS; k++) begin
            if (c) begin
                if (up) begin
                    if (v[k] == 4'd9) r[k] = 4'd0;
                    else begin
                        r[k] = v[k] + 4'd1;
                        c    = 1'b0;
                    end
                end else begin
                    if (v[k] == 4'd0) r[k] = 4'd9;
                    else begin
                        r[k] = v[k] - 4'd1;
                        c    = 1'b0;
                    end
                end
            end
        end
        return {c, r};
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        unique case (d)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1F;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign ev = ~bus.key_n & key_q;

    always_comb begin
        logic [4*CNT_DIGITS:0] res;
        wrap = '0;
        nxt  = '0;
        res  = '0;
        for (int i = 0; i < N_CH; i++) begin
            res     = bcd_step(cnt[i], bus.up_dn);
            wrap[i] = res[4*CNT_DIGITS];
            nxt[i]  = res[4*CNT_DIGITS-1:0];
        end
    end

`ifdef KEY_DISP_DP_EN
    localparam int LW = (N_CH > 1) ? $clog2(N_CH) : 1;
    logic          last_v;
    logic [LW-1:0] last_i;
    logic [LW-1:0] ev_idx;

    always_comb begin
        ev_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ev[i]) ev_idx = LW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_v <= 1'b0;
            last_i <= '0;
        end else if (bus.clr) begin
            last_v <= 1'b0;
        end else if (|ev) begin
            last_v <= 1'b1;
            last_i <= ev_idx;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= '1;
            cnt   <= '0;
            ovf_q <= '0;
        end else begin
            key_q <= bus.key_n;
            if (bus.clr) begin
                cnt   <= '0;
                ovf_q <= '0;
            end else begin
                ovf_q <= ev & wrap;
                for (int i = 0; i < N_CH; i++) begin
                    if (ev[i]) cnt[i] <= nxt[i];
                end
            end
        end
    end

    assign nxt_idx = (dig == IW'(N_DIGITS - 1)) ? '0 : dig + IW'(1);

    // Segment pattern for the digit that becomes active on the next rotation.
    always_comb begin
        seg_nxt = 8'hFF;
        dp_lit  = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < CNT_DIGITS; k++) begin
                if (c * CNT_DIGITS + k == int'(nxt_idx)) begin
                    seg_nxt = seg7(cnt[c][k]);
`ifdef KEY_DISP_DP_EN
                    dp_lit  = last_v && (k == 0) && (int'(last_i) == c);
`endif
                end
            end
        end
        seg_nxt[0] = seg_nxt[0] & ~dp_lit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre   <= '0;
            dig   <= '0;
            sel_q <= N_DIGITS'(1);
            seg_q <= 8'hFF;
        end else if (pre == PW'(SCAN_DIV - 1)) begin
            pre   <= '0;
            dig   <= nxt_idx;
            sel_q <= N_DIGITS'(1) << nxt_idx;
            seg_q <= seg_nxt;
        end else begin
            pre   <= pre + PW'(1);
        end
    end

    assign bus.seg = seg_q;
    assign bus.sel = sel_q;
    assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_key_count_disp.sv
// Directed bench for key_count_disp: one 4x1-digit and one 3x2-digit instance.
// Both use SCAN_DIV=4 so a full 6-digit scan takes 24 clocks.
module tb_key_count_disp;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ovf_cnt [8];

    key_count_disp_if #(.N_CH(4), .N_DIGITS(6)) ia ();
    key_count_disp_if #(.N_CH(3), .N_DIGITS(6)) ib ();

    key_count_disp #(
        .N_CH(4), .CNT_DIGITS(1), .N_DIGITS(6), .SCAN_DIV(4)
    ) u_a (
        .clk(clk), .rst(rst), .bus(ia.slave)
    );

    key_count_disp #(
        .N_CH(3), .CNT_DIGITS(2), .N_DIGITS(6), .SCAN_DIV(4)
    ) u_b (
        .clk(clk), .rst(rst), .bus(ib.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_ovf();
        for (int i = 0; i < 8; i++) ovf_cnt[i] = 0;
    endtask

    task automatic sample_ovf(input bit which);
        for (int i = 0; i < 4; i++) begin
            if (which == 1'b0 && ia.ovf[i]) ovf_cnt[i]++;
            if (which == 1'b1 && i < 3 && ib.ovf[i]) ovf_cnt[i]++;
        end
    endtask

    // Press and release one key; ovf sampled on both following negedges.
    task automatic press(input bit which, input int ch);
        if (which) ib.key_n[ch] = 1'b0;
        else       ia.key_n[ch] = 1'b0;
        @(negedge clk);
        sample_ovf(which);
        if (which) ib.key_n[ch] = 1'b1;
        else       ia.key_n[ch] = 1'b1;
        @(negedge clk);
        sample_ovf(which);
    endtask

    function automatic logic [5:0] get_sel(input bit which);
        return which ? ib.sel : ia.sel;
    endfunction

    // Wait for a fresh arrival of sel at target, bounded to 100 clocks each way.
    task automatic wait_sel(input bit which, input logic [5:0] target,
                            input string tag);
        int n;
        n = 0;
        while (get_sel(which) == target && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (get_sel(which) != target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(get_sel(which)), 32'(target));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        clr_ovf();
        rst      = 1'b1;
        ia.key_n = '1;
        ia.up_dn = 1'b1;
        ia.clr   = 1'b0;
        ib.key_n = '1;
        ib.up_dn = 1'b1;
        ib.clr   = 1'b0;

        // 1: reset values, then first rotation after 4 clocks
        @(negedge clk);
        chk("rst_seg", 32'(ia.seg), 32'h FF);
        chk("rst_sel", 32'(ia.sel), 32'h01);
        chk("rst_ovf", 32'(ia.ovf), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("scan1_sel", 32'(ia.sel), 32'h02);
        chk("scan1_seg", 32'(ia.seg), 32'h03);

        // 2: three up events on ch0
        clr_ovf();
        repeat (3) press(1'b0, 0);
        chk("t2_ovf", 32'(ovf_cnt[0]), 32'd0);
        wait_sel(1'b0, 6'b000001, "t2_sel");
        chk("t2_seg", 32'(ia.seg), 32'h0D);

        // 3: ten events on ch2 wrap to 0 with a single ovf pulse
        clr_ovf();
        repeat (10) press(1'b0, 2);
        chk("t3_ovf", 32'(ovf_cnt[2]), 32'd1);
        wait_sel(1'b0, 6'b000100, "t3_sel");
        chk("t3_seg", 32'(ia.seg), 32'h03);

        // 4: down from 0 on ch1 wraps to 9; unused digits blank
        clr_ovf();
        ia.up_dn = 1'b0;
        press(1'b0, 1);
        chk("t4_ovf", 32'(ovf_cnt[1]), 32'd1);
        wait_sel(1'b0, 6'b000010, "t4_sel1");
        chk("t4_seg1", 32'(ia.seg), 32'h09);
        wait_sel(1'b0, 6'b010000, "t4_sel4");
        chk("t4_seg4", 32'(ia.seg), 32'hFF);
        wait_sel(1'b0, 6'b100000, "t4_sel5");
        chk("t4_seg5", 32'(ia.seg), 32'hFF);
        ia.up_dn = 1'b1;

        // asynchronous reset in mid-dwell clears everything
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel", 32'(ia.sel), 32'h01);
        chk("arst_seg", 32'(ia.seg), 32'hFF);
        @(negedge clk);
        rst = 1'b0;
        wait_sel(1'b0, 6'b000010, "arst_sel1");
        chk("arst_seg1", 32'(ia.seg), 32'h03);

        // 5: held key counts once
        ia.key_n[3] = 1'b0;
        repeat (20) @(negedge clk);
        ia.key_n[3] = 1'b1;
        wait_sel(1'b0, 6'b001000, "t5_sel3");
        chk("t5_hold", 32'(ia.seg), 32'h9F);

        // clr wins over a same-cycle event
        ia.key_n[0] = 1'b0;
        ia.clr      = 1'b1;
        @(negedge clk);
        chk("t5_clr_ovf", 32'(ia.ovf), 32'h0);
        ia.clr      = 1'b0;
        ia.key_n[0] = 1'b1;
        for (int d = 0; d < 4; d++) begin
            wait_sel(1'b0, 6'(1 << d), "t5_sel");
            chk("t5_clr_seg", 32'(ia.seg), 32'h03);
        end

        // 6: two-digit channels, 15 then 85 more events on ch0
        clr_ovf();
        repeat (15) press(1'b1, 0);
        wait_sel(1'b1, 6'b000001, "t6_sel0");
`ifdef KEY_DISP_DP_EN
        chk("t6_d0", 32'(ib.seg), 32'h48);
`else
        chk("t6_d0", 32'(ib.seg), 32'h49);
`endif
        wait_sel(1'b1, 6'b000010, "t6_sel1");
        chk("t6_d1", 32'(ib.seg), 32'h9F);
        repeat (85) press(1'b1, 0);
        chk("t6_ovf", 32'(ovf_cnt[0]), 32'd1);
        wait_sel(1'b1, 6'b000001, "t6_sel0b");
`ifdef KEY_DISP_DP_EN
        chk("t6_d0b", 32'(ib.seg), 32'h02);
`else
        chk("t6_d0b", 32'(ib.seg), 32'h03);
`endif
        wait_sel(1'b1, 6'b000010, "t6_sel1b");
        chk("t6_d1b", 32'(ib.seg), 32'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
